// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bundle for the program-counter generator.
// The master modport is the PC generator itself. The slave modport is the
// block on the far side, which combines IF, the stall controller and EX.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall_i;
    logic               if_ready_i;
    logic [ADDR_W-1:0]  pc_o;
    logic               pc_valid_o;
    logic               pred_taken_o;
    logic               ex_jump_i;
    logic [ADDR_W-1:0]  ex_jump_addr_i;
    logic [ADDR_W-1:0]  ex_pc_i;

    modport master (
        input  stall_i, if_ready_i, ex_jump_i, ex_jump_addr_i, ex_pc_i,
        output pc_o, pc_valid_o, pred_taken_o
    );

    modport slave (
        output stall_i, if_ready_i, ex_jump_i, ex_jump_addr_i, ex_pc_i,
        input  pc_o, pc_valid_o, pred_taken_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the RV32 front end.
// It presents the fetch address through a valid/ready handshake and freezes
// while stall bit 0 is set. An EX redirect that arrives during a stall is
// parked and applied on the first unstalled edge, so no redirect is lost.
// Define BTB_EN to add a direct-mapped branch target buffer. The buffer
// predicts the next fetch address from the current pc_o.
module pc_gen #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter int                 STALL_W   = 6,
    parameter int                 BTB_DEPTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
    logic              pendV_q, pendV_d;
    logic              pred_q, pred_d;
    logic              stalled;
    logic              fire;
    logic              btbHit;
    logic [ADDR_W-1:0] btbTarget;
    logic              unusedBits;

    // Catch bad parameter combinations at elaboration.
    if (ADDR_W < 8 || STALL_W < 1 || BTB_DEPTH < 2 ||
        (BTB_DEPTH & (BTB_DEPTH - 1)) != 0 || RESET_VEC[1:0] != 2'b00) begin : gBadParams
        $error("pc_gen: illegal parameter combination");
    end

    function automatic logic [ADDR_W-1:0] align4(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    assign stalled    = bus.stall_i[0];
    assign fire       = (state_q == RUN) && !stalled && bus.if_ready_i;
    assign unusedBits = ^{bus.stall_i, bus.ex_pc_i};

    assign bus.pc_o         = pc_q;
    assign bus.pc_valid_o   = (state_q == RUN);
    assign bus.pred_taken_o = pred_q;

`ifdef BTB_EN
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              btbValid_q  [BTB_DEPTH];
    logic [TAG_W-1:0]  btbTag_q    [BTB_DEPTH];
    logic [ADDR_W-1:0] btbTarget_q [BTB_DEPTH];
    logic [IDX_W-1:0]  rdIdx, wrIdx;

    assign rdIdx     = pc_q[IDX_W+1:2];
    assign wrIdx     = bus.ex_pc_i[IDX_W+1:2];
    assign btbHit    = btbValid_q[rdIdx] && (btbTag_q[rdIdx] == pc_q[ADDR_W-1:IDX_W+2]);
    assign btbTarget = btbTarget_q[rdIdx];

    // Train the valid bits on every redirect, even while stalled. Reset wipes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) btbValid_q[i] <= 1'b0;
        end else if (bus.ex_jump_i) begin
            btbValid_q[wrIdx] <= 1'b1;
        end
    end

    // Tag and target payload; its valid bit decides whether it means anything.
    always_ff @(posedge clk) begin
        if (!rst && bus.ex_jump_i) begin
            btbTag_q[wrIdx]    <= bus.ex_pc_i[ADDR_W-1:IDX_W+2];
            btbTarget_q[wrIdx] <= align4(bus.ex_jump_addr_i);
        end
    end
`else
    assign btbHit    = 1'b0;
    assign btbTarget = '0;
`endif

    // State, PC, prediction flag and parked redirect; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            pred_q     <= 1'b0;
            pendV_q    <= 1'b0;
            pendAddr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pred_q     <= pred_d;
            pendV_q    <= pendV_d;
            pendAddr_q <= pendAddr_d;
        end
    end

    // Next-PC priority: live redirect, park redirect, drain parked, predict, sequential.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pred_d     = pred_q;
        pendV_d    = pendV_q;
        pendAddr_d = pendAddr_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.ex_jump_i && !stalled) begin
                    pc_d    = align4(bus.ex_jump_addr_i);
                    pendV_d = 1'b0;
                    pred_d  = 1'b0;
                end else if (bus.ex_jump_i) begin
                    pendV_d    = 1'b1;
                    pendAddr_d = align4(bus.ex_jump_addr_i);
                end else if (pendV_q && !stalled) begin
                    pc_d    = pendAddr_q;
                    pendV_d = 1'b0;
                    pred_d  = 1'b0;
                end else if (fire && btbHit) begin
                    pc_d   = btbTarget;
                    pred_d = 1'b1;
                end else if (fire) begin
                    pc_d   = pc_q + ADDR_W'(4);
                    pred_d = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen.
// A behavioural model tracks the expected fetch address. Every cycle the
// DUT is compared against it. Directed literal checks pin the model to the
// documented scenarios, and a long randomized run follows.
module tb_pc_gen;

    localparam int          ADDR_W    = 32;
    localparam int          STALL_W   = 6;
    localparam int          BTB_DEPTH = 16;
    localparam logic [31:0] RST_VEC   = 32'h80;
    localparam logic [31:0] DFLT_EXPC = 32'h5555_0008;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pc_gen_if #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) bus ();

    pc_gen #(
        .ADDR_W(ADDR_W), .RESET_VEC(RST_VEC), .STALL_W(STALL_W), .BTB_DEPTH(BTB_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          modelLive = 0;
    bit          mValid;
    bit          mPred;
    bit          mPendV;
    logic [31:0] mPc;
    logic [31:0] mPendAddr;
    bit          stalled;
    bit          predHit;
    logic [31:0] predTgt;
    bit          mBtbV   [BTB_DEPTH];
    logic [31:0] mBtbPc  [BTB_DEPTH];
    logic [31:0] mBtbTgt [BTB_DEPTH];
    int          slot;

    function automatic int slotOf(input logic [31:0] a);
        return int'(a >> 2) % BTB_DEPTH;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [5:0] st, input bit rdy,
                                 input bit jmp, input logic [31:0] ja, input logic [31:0] ep);
        rst                = r;
        bus.stall_i        = st;
        bus.if_ready_i     = rdy;
        bus.ex_jump_i      = jmp;
        bus.ex_jump_addr_i = ja;
        bus.ex_pc_i        = ep;
        @(negedge clk);
    endtask

    // Reference model: apply the next-PC rules once per rising edge.
    always @(posedge clk) begin
        if (rst) begin
            modelLive = 1;
            mValid    = 0;
            mPc       = RST_VEC;
            mPred     = 0;
            mPendV    = 0;
            for (int i = 0; i < BTB_DEPTH; i++) mBtbV[i] = 0;
        end else if (modelLive) begin
            stalled = bus.stall_i[0];
            predHit = 0;
            predTgt = 32'h0;
`ifdef BTB_EN
            slot = slotOf(mPc);
            if (mBtbV[slot] && (mBtbPc[slot] >> 2) == (mPc >> 2)) begin
                predHit = 1;
                predTgt = mBtbTgt[slot];
            end
`endif
            if (!mValid) begin
                mValid = 1;
            end else if (bus.ex_jump_i && !stalled) begin
                mPc    = bus.ex_jump_addr_i & ~32'h3;
                mPendV = 0;
                mPred  = 0;
            end else if (bus.ex_jump_i) begin
                mPendV    = 1;
                mPendAddr = bus.ex_jump_addr_i & ~32'h3;
            end else if (mPendV && !stalled) begin
                mPc    = mPendAddr;
                mPendV = 0;
                mPred  = 0;
            end else if (!stalled && bus.if_ready_i) begin
                mPc   = predHit ? predTgt : mPc + 32'd4;
                mPred = predHit;
            end
`ifdef BTB_EN
            if (bus.ex_jump_i) begin
                slot          = slotOf(bus.ex_pc_i);
                mBtbV[slot]   = 1;
                mBtbPc[slot]  = bus.ex_pc_i;
                mBtbTgt[slot] = bus.ex_jump_addr_i & ~32'h3;
            end
`endif
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("pc_valid", {31'h0, bus.pc_valid_o}, {31'h0, mValid});
            checkOutput("pc", bus.pc_o, mPc);
            if (mValid) checkOutput("pred_taken", {31'h0, bus.pred_taken_o}, {31'h0, mPred});
        end
    end

    initial begin
        logic [5:0]  st;
        logic [31:0] ja;
        logic [31:0] ep;
        bit          jmp;
        bit          r;

        // Reset and boot sequence
        applyStimulus(1, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        applyStimulus(1, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("reset_pc", bus.pc_o, 32'h80);
        checkOutput("reset_valid", {31'h0, bus.pc_valid_o}, 32'h0);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("boot_valid", {31'h0, bus.pc_valid_o}, 32'h1);
        checkOutput("boot_pc", bus.pc_o, 32'h80);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("seq_84", bus.pc_o, 32'h84);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("seq_88", bus.pc_o, 32'h88);

        // Backpressure from IF
        applyStimulus(0, 6'h0, 1, 1, 32'h100, DFLT_EXPC);
        checkOutput("jump_100", bus.pc_o, 32'h100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 6'h0, 0, 0, 32'h0, DFLT_EXPC);
            checkOutput("notready_hold", bus.pc_o, 32'h100);
        end
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("ready_advance", bus.pc_o, 32'h104);

        // Redirects during a stall; the newer one wins
        applyStimulus(0, 6'h1, 1, 1, 32'h2000, DFLT_EXPC);
        checkOutput("stall_hold_a", bus.pc_o, 32'h104);
        applyStimulus(0, 6'h3, 1, 1, 32'h3000, DFLT_EXPC);
        checkOutput("stall_hold_b", bus.pc_o, 32'h104);
        applyStimulus(0, 6'h1, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("stall_hold_c", bus.pc_o, 32'h104);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("pending_apply", bus.pc_o, 32'h3000);

        // Unaligned target, no leftover pending state
        applyStimulus(0, 6'h0, 1, 1, 32'h3, DFLT_EXPC);
        checkOutput("align_target", bus.pc_o, 32'h0);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("no_pending", bus.pc_o, 32'h4);

        // Address-space wrap
        applyStimulus(0, 6'h0, 1, 1, 32'hFFFF_FFFC, DFLT_EXPC);
        checkOutput("top_pc", bus.pc_o, 32'hFFFF_FFFC);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("wrap_pc", bus.pc_o, 32'h0);

        // Reset mid-operation discards a pending redirect
        applyStimulus(0, 6'h1, 1, 1, 32'h700, DFLT_EXPC);
        checkOutput("park_hold", bus.pc_o, 32'h0);
        applyStimulus(1, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("midrst_valid", {31'h0, bus.pc_valid_o}, 32'h0);
        checkOutput("midrst_pc", bus.pc_o, 32'h80);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("reboot_pc", bus.pc_o, 32'h80);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("pend_dropped", bus.pc_o, 32'h84);

`ifdef BTB_EN
        // BTB training, prediction and flush on reset
        applyStimulus(0, 6'h0, 1, 1, 32'h400, 32'h40);
        checkOutput("btb_train", bus.pc_o, 32'h400);
        applyStimulus(0, 6'h0, 1, 1, 32'h40, DFLT_EXPC);
        checkOutput("btb_refetch", bus.pc_o, 32'h40);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("btb_pred_pc", bus.pc_o, 32'h400);
        checkOutput("btb_pred_flag", {31'h0, bus.pred_taken_o}, 32'h1);
        applyStimulus(1, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        applyStimulus(0, 6'h0, 1, 1, 32'h40, DFLT_EXPC);
        checkOutput("btb_flush_refetch", bus.pc_o, 32'h40);
        applyStimulus(0, 6'h0, 1, 0, 32'h0, DFLT_EXPC);
        checkOutput("btb_flushed_pc", bus.pc_o, 32'h44);
        checkOutput("btb_flushed_flag", {31'h0, bus.pred_taken_o}, 32'h0);
`endif

        // Randomized traffic confined to a small loop region, so the BTB gets hits
        for (int n = 0; n < 3000; n++) begin
            st    = 6'($urandom);
            st[0] = ($urandom_range(0, 3) == 0);
            jmp   = ($urandom_range(0, 9) == 0);
            r     = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 7))
                0:       ja = $urandom;
                1:       ja = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: ja = 32'h80 + 32'($urandom_range(0, 63)) * 4 + ($urandom & 32'h3);
            endcase
            if ($urandom_range(0, 1) == 0) ep = mPc;
            else ep = 32'h80 + 32'($urandom_range(0, 63)) * 4;
            applyStimulus(r, st, ($urandom_range(0, 3) != 0), jmp, ja, ep);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
